// File: rtl/down_counter_timer_pkg.sv
// Shared constants for the down-counter/timer: FSM state encodings and the
// default counter width.
package down_counter_timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/down_count_core.sv
// Datapath of the down-counter: count register, reload register, decrement
// and zero detect. Driven by load / dec / reload strobes from the control FSM.
module down_count_core
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  input  logic             reload,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] reload_val;

  // Count register: load beats reload beats decrement; otherwise hold.
  // The control side only asserts dec when the count is nonzero, so the
  // register can never wrap below zero.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count      <= '0;
      reload_val <= '0;
    end else if (load) begin
      count      <= in;
      reload_val <= in;
    end else if (reload) begin
      count      <= reload_val;
    end else if (dec) begin
      count      <= count - WIDTH'(1);
    end
  end

  assign out  = count;
  assign zero = (count == '0);

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with one-shot and periodic (auto-reload) modes.
// The FSM and the registered done/busy flags live here; the count and reload
// registers live in down_count_core.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_n,
  input  logic             enp,
  input  logic             ent,
  input  logic             mode,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             done,
  output logic             busy
);

  logic [1:0] state;
  logic [1:0] next_state;
  logic       done_next;
  logic       zero;
  logic       count_edge;
  logic       load;
  logic       dec;
  logic       reload;

  // A counting edge needs RUN, both enables, and no load on the same edge.
  assign load       = ~load_n;
  assign count_edge = (state == ST_RUN) & enp & ent & load_n;
  assign dec        = count_edge & ~zero;
  assign reload     = count_edge & zero & mode;

  down_count_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .clr    (clr),
    .load   (load),
    .dec    (dec),
    .reload (reload),
    .in     (in),
    .out    (out),
    .zero   (zero)
  );

  // Terminal count is purely combinational so it can be cascaded via ent.
  assign tc = ent & zero;

  // Next-state and expiry decode; an unused encoding falls back to IDLE.
  always_comb begin
    next_state = state;
    done_next  = 1'b0;
    if (state != ST_IDLE && state != ST_RUN && state != ST_DONE) begin
      next_state = ST_IDLE;
    end
    if (load) begin
      next_state = ST_RUN;
    end else if (count_edge && zero) begin
      done_next = 1'b1;
      if (!mode) begin
        next_state = ST_DONE;
      end
    end
  end

  // State, done pulse and busy flag; busy is registered alongside state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_IDLE;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= next_state;
      done  <= done_next;
      busy  <= (next_state == ST_RUN);
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: a table of directed vectors
// plus hand-written sequences for asynchronous clear and long holds.
module tb_down_counter_timer;

  logic       clk;
  logic       clr;
  logic       load_n;
  logic       enp;
  logic       ent;
  logic       mode;
  logic [3:0] in;
  logic [3:0] out;
  logic       tc;
  logic       done;
  logic       busy;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       load_n;
    logic       enp;
    logic       ent;
    logic       mode;
    logic [3:0] in;
    logic [3:0] exp_out;
    logic       exp_tc;
    logic       exp_done;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  down_counter_timer #(.WIDTH(4)) dut (
    .clk    (clk),
    .clr    (clr),
    .load_n (load_n),
    .enp    (enp),
    .ent    (ent),
    .mode   (mode),
    .in     (in),
    .out    (out),
    .tc     (tc),
    .done   (done),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e_out, input int e_tc,
                           input int e_done, input int e_busy);
    check({tag, " out"},  int'(out),  e_out);
    check({tag, " tc"},   int'(tc),   e_tc);
    check({tag, " done"}, int'(done), e_done);
    check({tag, " busy"}, int'(busy), e_busy);
  endtask

  function automatic void add(input logic ld_n, input logic p, input logic t,
                              input logic m, input logic [3:0] d,
                              input logic [3:0] e_out, input logic e_tc,
                              input logic e_done, input logic e_busy);
    vec_t v;
    v.load_n   = ld_n;
    v.enp      = p;
    v.ent      = t;
    v.mode     = m;
    v.in       = d;
    v.exp_out  = e_out;
    v.exp_tc   = e_tc;
    v.exp_done = e_done;
    v.exp_busy = e_busy;
    vecs.push_back(v);
  endfunction

  // Drive inputs on the falling edge, let one rising edge happen, sample 1ns later.
  task automatic step(input logic ld_n, input logic p, input logic t,
                      input logic m, input logic [3:0] d);
    @(negedge clk);
    load_n = ld_n;
    enp    = p;
    ent    = t;
    mode   = m;
    in     = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    clr    = 1'b1;
    load_n = 1'b1;
    enp    = 1'b1;
    ent    = 1'b1;
    mode   = 1'b0;
    in     = 4'd0;

    // Reset state while clr is held, both before and after clock edges.
    #2;
    check_all("rst0", 0, 1, 0, 0);
    @(posedge clk);
    #1;
    check_all("rst1", 0, 1, 0, 0);

    // IDLE after reset: enables high, no load -> nothing happens.
    add(1, 1, 1, 0, 4'd0,  4'd0,  1, 0, 0);
    add(1, 1, 1, 0, 4'd0,  4'd0,  1, 0, 0);
    // One-shot load 3: 3,2,1,0 then done on the 4th count edge.
    add(0, 1, 1, 0, 4'd3,  4'd3,  0, 0, 1);
    add(1, 1, 1, 0, 4'd0,  4'd2,  0, 0, 1);
    add(1, 1, 1, 0, 4'd0,  4'd1,  0, 0, 1);
    add(1, 1, 1, 0, 4'd0,  4'd0,  1, 0, 1);
    add(1, 1, 1, 0, 4'd0,  4'd0,  1, 1, 0);
    add(1, 1, 1, 0, 4'd0,  4'd0,  1, 0, 0);
    add(1, 1, 1, 0, 4'd0,  4'd0,  1, 0, 0);
    // Periodic load 2 from DONE: 2,1,0 then reload with a done pulse, x3.
    add(0, 1, 1, 1, 4'd2,  4'd2,  0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      add(1, 1, 1, 1, 4'd0, 4'd1, 0, 0, 1);
      add(1, 1, 1, 1, 4'd0, 4'd0, 1, 0, 1);
      add(1, 1, 1, 1, 4'd0, 4'd2, 0, 1, 1);
    end
    // Enable gating at 7: enp low x3, ent low x2, then resume.
    add(0, 1, 1, 0, 4'd7,  4'd7,  0, 0, 1);
    add(1, 0, 1, 0, 4'd0,  4'd7,  0, 0, 1);
    add(1, 0, 1, 0, 4'd0,  4'd7,  0, 0, 1);
    add(1, 0, 1, 0, 4'd0,  4'd7,  0, 0, 1);
    add(1, 1, 0, 0, 4'd0,  4'd7,  0, 0, 1);
    add(1, 1, 0, 0, 4'd0,  4'd7,  0, 0, 1);
    add(1, 1, 1, 0, 4'd0,  4'd6,  0, 0, 1);
    add(1, 1, 1, 0, 4'd0,  4'd5,  0, 0, 1);
    add(1, 1, 1, 0, 4'd0,  4'd4,  0, 0, 1);
    // Load 10 at out = 4 with enables high: no decrement on that edge.
    add(0, 1, 1, 0, 4'b1010, 4'd10, 0, 0, 1);
    add(1, 1, 1, 0, 4'd0,  4'd9,  0, 0, 1);
    // Load 0 expires on the first count edge.
    add(0, 1, 1, 0, 4'd0,  4'd0,  1, 0, 1);
    add(1, 1, 1, 0, 4'd0,  4'd0,  1, 1, 0);
    // tc is gated by ent.
    add(1, 1, 0, 0, 4'd0,  4'd0,  0, 0, 0);

    @(negedge clk);
    clr = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].load_n, vecs[i].enp, vecs[i].ent, vecs[i].mode, vecs[i].in);
      check_all($sformatf("v%0d", i), int'(vecs[i].exp_out), int'(vecs[i].exp_tc),
                int'(vecs[i].exp_done), int'(vecs[i].exp_busy));
    end

    // DONE hold: enables high for 10 more edges, no further expiry.
    for (int k = 0; k < 10; k++) begin
      step(1, 1, 1, 0, 4'd0);
      check_all($sformatf("donehold%0d", k), 0, 1, 0, 0);
    end

    // Asynchronous clear mid-count at out = 5.
    step(0, 1, 1, 0, 4'd9);
    for (int k = 0; k < 4; k++) step(1, 1, 1, 0, 4'd0);
    check_all("pre_clr", 5, 0, 0, 1);
    @(negedge clk);
    #2;
    clr = 1'b1;
    #1;
    check_all("async_clr", 0, 1, 0, 0);
    @(negedge clk);
    clr = 1'b0;

    // Clear cancels a pending done pulse.
    step(0, 1, 1, 0, 4'd0);
    step(1, 1, 1, 0, 4'd0);
    check_all("pend_done", 0, 1, 1, 0);
    #1;
    clr = 1'b1;
    #1;
    check_all("clr_cancel", 0, 1, 0, 0);
    @(negedge clk);
    clr = 1'b0;

    // IDLE after clear: enables high, no load, nothing counts or expires.
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 1, 1, 4'd0);
      check_all($sformatf("idle%0d", k), 0, 1, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable synchronous 4-bit down-counter/timer. It is the counting-down counterpart to the 74HC161-style up-counter used for the TD4 program counter and registers.
- Parallel-loads a start value, decrements on enabled clock edges, and flags expiry.
- Runs in one-shot or periodic (auto-reload) mode.
- Used as a programmable clock divider / delay for the TD4 board's step clock and for I/O timing.

Parameters:
- WIDTH, 4, counter and load-value width in bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clr  input  1  asynchronous active-high reset.
- load_n  input  1  synchronous active-low parallel load of in.
- enp  input  1  count enable (parallel); both enp and ent required to count.
- ent  input  1  count enable (trickle); also gates tc.
- mode  input  1  0 = one-shot, 1 = periodic auto-reload; sampled on every counting edge.
- in  input  WIDTH  load value.
- out  output  WIDTH  current count (registered).
- tc  output  1  terminal count, combinational: ent & (out == 0).
- done  output  1  registered one-cycle expiry pulse.
- busy  output  1  registered; 1 while state is RUN.

Behaviour:
- Reset: clr high asynchronously forces the following, held while clr is high:
  - out = 0, internal reload register = 0, state = IDLE, done = 0, busy = 0.
  - tc follows its equation, so tc = 1 if ent = 1.
- Priority per rising edge: clr > load > count > hold.
- States:
  - IDLE: counting ignored; out holds.
  - RUN: counting active.
  - DONE: counting ignored; out holds 0. Exits only via load or clr.
- Load (load_n = 0, any state):
  - out <= in, reload <= in, state <= RUN, done <= 0.
  - Load beats an enabled count on the same edge: no decrement that edge.
- Count edge = RUN & enp & ent & load_n:
  - out != 0: out <= out - 1; done <= 0.
  - out == 0, mode = 1: out <= reload; done <= 1 for exactly one cycle; stays RUN.
  - out == 0, mode = 0: out stays 0; done <= 1 for one cycle; state <= DONE.
- Non-count edges in RUN: out holds; done <= 0.
- Expiry latency: after loading value N, done asserts in the cycle after the (N+1)th count edge.
  - Periodic period = reload + 1 count edges.
  - Load of 0 expires on the first count edge.
- No wrap-around via arithmetic: out never decrements below 0. The only 0 -> nonzero transitions are reload or load.
- busy = (state == RUN), registered with state.
- clr mid-operation aborts immediately; any pending done pulse is cancelled.
- Asynchronous inputs are not synchronised here; they are synchronous to clk by contract.

Decomposition:
- Shared header (td4 defines include):
  - state encodings IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10;
  - default WIDTH = 4.
- One natural sub-module: down_count_core. It holds the out/reload registers, the decrement, and the zero detect, driven by load/dec/reload strobes.
- The FSM and the done/busy flags live in the top.

Test Plan:
- Reset: assert clr mid-count at out = 4'd5 -> out = 0, busy = 0, done = 0 immediately (before the next edge); tc = 1 with ent = 1.
- One-shot: load in = 4'd3, mode = 0, enp = ent = 1 -> out goes 3, 2, 1, 0. done is high one cycle after the 4th count edge, busy drops, out stays 0 for 10 more cycles.
- Periodic: load 4'd2, mode = 1, enables high -> out cycles 2, 1, 0, 2, 1, 0, with done pulsing once every 3 count edges for 3 periods.
- Enable gating: in RUN at out = 4'd7, toggle enp = 0 for 3 edges, then ent = 0 for 2 edges -> out holds 7 and tc = 0 throughout; counting resumes when both are high.
- Simultaneous load and count: at out = 4'd4, load in = 4'b1010 with enables high -> out = 10 next cycle, no decrement, done = 0. Then load 4'd0 -> done pulses on the first count edge.
- DONE and IDLE hold: after one-shot expiry, hold enables high for 5 edges -> out = 0 and no further done. After reset with no load, enables high -> out stays 0, done = 0.
